// File: rtl/decode_stage_pkg.sv
// Shared Y86-64 constants for the decode/write-back stage: icodes, register IDs, widths.
package decode_stage_pkg;

  localparam int NIBBLE = 4;
  localparam int D_WORD = 64;
  localparam int NREG   = 15;
  localparam int WORD_W = D_WORD;

  localparam logic [NIBBLE-1:0] IHALT   = 4'h0;
  localparam logic [NIBBLE-1:0] INOP    = 4'h1;
  localparam logic [NIBBLE-1:0] IRRMOVQ = 4'h2;
  localparam logic [NIBBLE-1:0] IIRMOVQ = 4'h3;
  localparam logic [NIBBLE-1:0] IRMMOVQ = 4'h4;
  localparam logic [NIBBLE-1:0] IMRMOVQ = 4'h5;
  localparam logic [NIBBLE-1:0] IOPQ    = 4'h6;
  localparam logic [NIBBLE-1:0] IJXX    = 4'h7;
  localparam logic [NIBBLE-1:0] ICALL   = 4'h8;
  localparam logic [NIBBLE-1:0] IRET    = 4'h9;
  localparam logic [NIBBLE-1:0] IPUSHQ  = 4'hA;
  localparam logic [NIBBLE-1:0] IPOPQ   = 4'hB;

  localparam logic [NIBBLE-1:0] RRSP  = 4'h4;
  localparam logic [NIBBLE-1:0] RNONE = 4'hF;

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of D-register fields, forwarding sources, write-back ports and decode results.
interface decode_stage_if;
  import decode_stage_pkg::*;

  logic [NIBBLE-1:0] D_icode;
  logic [NIBBLE-1:0] D_rA;
  logic [NIBBLE-1:0] D_rB;
  logic [D_WORD-1:0] D_valP;
  logic [NIBBLE-1:0] e_dstE;
  logic [D_WORD-1:0] e_valE;
  logic [NIBBLE-1:0] M_dstE;
  logic [D_WORD-1:0] M_valE;
  logic [NIBBLE-1:0] M_dstM;
  logic [D_WORD-1:0] m_valM;
  logic [NIBBLE-1:0] W_dstE;
  logic [D_WORD-1:0] W_valE;
  logic [NIBBLE-1:0] W_dstM;
  logic [D_WORD-1:0] W_valM;
  logic [NIBBLE-1:0] dbg_idx;
  logic [NIBBLE-1:0] d_srcA;
  logic [NIBBLE-1:0] d_srcB;
  logic [NIBBLE-1:0] d_dstE;
  logic [NIBBLE-1:0] d_dstM;
  logic [D_WORD-1:0] d_valA;
  logic [D_WORD-1:0] d_valB;
  logic [D_WORD-1:0] dbg_val;

  modport master (
    output D_icode, D_rA, D_rB, D_valP, e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
           W_dstE, W_valE, W_dstM, W_valM, dbg_idx,
    input  d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB, dbg_val
  );

  modport slave (
    input  D_icode, D_rA, D_rB, D_valP, e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
           W_dstE, W_valE, W_dstM, W_valM, dbg_idx,
    output d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB, dbg_val
  );

endinterface

// File: rtl/decode_stage_register_file.sv
// 15x64 architectural register file: two combinational read ports, a debug port and
// two write ports where the M port overrides the E port on an address collision.
module register_file
  import decode_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NIBBLE-1:0] rd_a_idx,
  output logic [D_WORD-1:0] rd_a_val,
  input  logic [NIBBLE-1:0] rd_b_idx,
  output logic [D_WORD-1:0] rd_b_val,
  input  logic [NIBBLE-1:0] dbg_idx,
  output logic [D_WORD-1:0] dbg_val,
  input  logic [NIBBLE-1:0] wr_e_idx,
  input  logic [D_WORD-1:0] wr_e_val,
  input  logic [NIBBLE-1:0] wr_m_idx,
  input  logic [D_WORD-1:0] wr_m_val
);

  logic [D_WORD-1:0] regs [NREG];

  // M write is issued last so it takes the register when both ports hit the same ID
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wr_e_idx != RNONE) regs[wr_e_idx] <= wr_e_val;
      if (wr_m_idx != RNONE) regs[wr_m_idx] <= wr_m_val;
    end
  end

  assign rd_a_val = (rd_a_idx == RNONE) ? '0 : regs[rd_a_idx];
  assign rd_b_val = (rd_b_idx == RNONE) ? '0 : regs[rd_b_idx];
  assign dbg_val  = (dbg_idx  == RNONE) ? '0 : regs[dbg_idx];

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode/write-back stage: register ID decode and E/M/W forwarding select
// in front of the architectural register file.
module decode_stage
  import decode_stage_pkg::*;
(
  input logic          clk,
  input logic          rst,
  decode_stage_if.slave bus
);

  logic [NIBBLE-1:0] src_a, src_b, dst_e, dst_m;
  logic [D_WORD-1:0] rf_a, rf_b, val_a, val_b;

  function automatic logic [D_WORD-1:0] fwd_sel(
    input logic [NIBBLE-1:0] src,
    input logic [NIBBLE-1:0] e_dst,  input logic [D_WORD-1:0] e_val,
    input logic [NIBBLE-1:0] mm_dst, input logic [D_WORD-1:0] mm_val,
    input logic [NIBBLE-1:0] me_dst, input logic [D_WORD-1:0] me_val,
    input logic [NIBBLE-1:0] wm_dst, input logic [D_WORD-1:0] wm_val,
    input logic [NIBBLE-1:0] we_dst, input logic [D_WORD-1:0] we_val,
    input logic [D_WORD-1:0] rf_val
  );
    if (src == RNONE)       return '0;
    else if (src == e_dst)  return e_val;
    else if (src == mm_dst) return mm_val;
    else if (src == me_dst) return me_val;
    else if (src == wm_dst) return wm_val;
    else if (src == we_dst) return we_val;
    else                    return rf_val;
  endfunction

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (bus.D_icode)
      IRRMOVQ: begin src_a = bus.D_rA; dst_e = bus.D_rB; end
      IIRMOVQ: dst_e = bus.D_rB;
      IRMMOVQ: begin src_a = bus.D_rA; src_b = bus.D_rB; end
      IMRMOVQ: begin src_b = bus.D_rB; dst_m = bus.D_rA; end
      IOPQ:    begin src_a = bus.D_rA; src_b = bus.D_rB; dst_e = bus.D_rB; end
      ICALL:   begin src_b = RRSP; dst_e = RRSP; end
      IRET:    begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; end
      IPUSHQ:  begin src_a = bus.D_rA; src_b = RRSP; dst_e = RRSP; end
      IPOPQ:   begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; dst_m = bus.D_rA; end
      default: ;
    endcase
  end

  always_comb begin
    val_b = fwd_sel(src_b, bus.e_dstE, bus.e_valE, bus.M_dstM, bus.m_valM,
                    bus.M_dstE, bus.M_valE, bus.W_dstM, bus.W_valM,
                    bus.W_dstE, bus.W_valE, rf_b);
    if (bus.D_icode == ICALL || bus.D_icode == IJXX)
      val_a = bus.D_valP;
    else
      val_a = fwd_sel(src_a, bus.e_dstE, bus.e_valE, bus.M_dstM, bus.m_valM,
                      bus.M_dstE, bus.M_valE, bus.W_dstM, bus.W_valM,
                      bus.W_dstE, bus.W_valE, rf_a);
  end

  register_file u_rf (
    .clk      (clk),
    .rst      (rst),
    .rd_a_idx (src_a),
    .rd_a_val (rf_a),
    .rd_b_idx (src_b),
    .rd_b_val (rf_b),
    .dbg_idx  (bus.dbg_idx),
    .dbg_val  (bus.dbg_val),
    .wr_e_idx (bus.W_dstE),
    .wr_e_val (bus.W_valE),
    .wr_m_idx (bus.W_dstM),
    .wr_m_val (bus.W_valM)
  );

  assign bus.d_srcA = src_a;
  assign bus.d_srcB = src_b;
  assign bus.d_dstE = dst_e;
  assign bus.d_dstM = dst_m;
  assign bus.d_valA = val_a;
  assign bus.d_valB = val_b;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset/write sweep, collision, and a table of
// decode/forwarding vectors with hand-computed expectations.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  decode_stage_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode, ra, rb;
    logic [63:0] valp;
    logic [3:0]  e_dste;  logic [63:0] e_vale;
    logic [3:0]  m_dste;  logic [63:0] m_vale;
    logic [3:0]  m_dstm;  logic [63:0] m_valm;
    logic [3:0]  w_dste;  logic [63:0] w_vale;
    logic [3:0]  w_dstm;  logic [63:0] w_valm;
    logic [3:0]  x_srca, x_srcb, x_dste, x_dstm;
    logic [63:0] x_vala, x_valb;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.D_icode = INOP; bus.D_rA = RNONE; bus.D_rB = RNONE; bus.D_valP = '0;
    bus.e_dstE = RNONE; bus.e_valE = '0;
    bus.M_dstE = RNONE; bus.M_valE = '0;
    bus.M_dstM = RNONE; bus.m_valM = '0;
    bus.W_dstE = RNONE; bus.W_valE = '0;
    bus.W_dstM = RNONE; bus.W_valM = '0;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [63:0] val);
    @(negedge clk);
    bus.W_dstE = idx; bus.W_valE = val;
    @(posedge clk);
    #1 bus.W_dstE = RNONE;
  endtask

  task automatic dbg(input logic [3:0] idx, input logic [63:0] exp, input string name);
    bus.dbg_idx = idx;
    #1 chk(name, bus.dbg_val, exp);
  endtask

  task automatic set_vec(input int i,
      input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vp,
      input logic [3:0] ed, input logic [63:0] ev, input logic [3:0] med, input logic [63:0] mev,
      input logic [3:0] mmd, input logic [63:0] mmv, input logic [3:0] wed, input logic [63:0] wev,
      input logic [3:0] wmd, input logic [63:0] wmv,
      input logic [3:0] xsa, input logic [3:0] xsb, input logic [3:0] xde, input logic [3:0] xdm,
      input logic [63:0] xva, input logic [63:0] xvb);
    vecs[i].icode = ic; vecs[i].ra = ra; vecs[i].rb = rb; vecs[i].valp = vp;
    vecs[i].e_dste = ed;  vecs[i].e_vale = ev;
    vecs[i].m_dste = med; vecs[i].m_vale = mev;
    vecs[i].m_dstm = mmd; vecs[i].m_valm = mmv;
    vecs[i].w_dste = wed; vecs[i].w_vale = wev;
    vecs[i].w_dstm = wmd; vecs[i].w_valm = wmv;
    vecs[i].x_srca = xsa; vecs[i].x_srcb = xsb; vecs[i].x_dste = xde; vecs[i].x_dstm = xdm;
    vecs[i].x_vala = xva; vecs[i].x_valb = xvb;
  endtask

  initial begin
    // Register state when the table runs: r2=0x22 r3=0x11 r4=0x100 r5=0x55 r6=0x66
    //         icode    rA  rB  valP    e_dstE/valE  M_dstE/valE  M_dstM/valM  W_dstE/valE  W_dstM/valM  srcA srcB dstE dstM valA    valB
    set_vec(0,  IOPQ,    2, 5, 0,      2, 'h1,      15, 0,       2, 'h2,      2, 'h3,      15, 0,       2, 5, 5, 15, 'h1,    'h55);
    set_vec(1,  IOPQ,    2, 5, 0,      15, 'h1,     15, 0,       2, 'h2,      2, 'h3,      15, 0,       2, 5, 5, 15, 'h2,    'h55);
    set_vec(2,  IOPQ,    2, 5, 0,      15, 'h1,     15, 0,       15, 'h2,     2, 'h3,      15, 0,       2, 5, 5, 15, 'h3,    'h55);
    set_vec(3,  IOPQ,    2, 5, 0,      15, 0,       15, 0,       15, 0,       15, 0,       15, 0,       2, 5, 5, 15, 'h22,   'h55);
    set_vec(4,  ICALL,   15, 15, 'h40, 4, 'h77,     15, 0,       15, 0,       15, 0,       15, 0,       15, 4, 4, 15, 'h40,  'h77);
    set_vec(5,  IIRMOVQ, 15, 7, 0,     15, 'h99,    15, 0,       15, 0,       15, 0,       15, 0,       15, 15, 7, 15, 0,    0);
    set_vec(6,  IPOPQ,   6, 15, 0,     15, 0,       15, 0,       15, 0,       15, 0,       15, 0,       4, 4, 4, 6, 'h100,   'h100);
    set_vec(7,  IMRMOVQ, 1, 3, 0,      15, 0,       3, 'h33,     15, 0,       15, 0,       15, 0,       15, 3, 15, 1, 0,     'h33);
    set_vec(8,  IRMMOVQ, 6, 2, 0,      15, 0,       15, 0,       15, 0,       15, 0,       6, 'h5A,     6, 2, 15, 15, 'h5A,  'h22);
    set_vec(9,  4'hC,    2, 5, 'h8,    2, 'h9,      15, 0,       15, 0,       15, 0,       15, 0,       15, 15, 15, 15, 0,   0);
    set_vec(10, IJXX,    15, 15, 'h1234, 15, 0,     15, 0,       15, 0,       15, 0,       15, 0,       15, 15, 15, 15, 'h1234, 0);
    set_vec(11, IRET,    15, 15, 0,    15, 0,       15, 0,       15, 0,       4, 'h7,      15, 0,       4, 4, 4, 15, 'h7,    'h7);
    set_vec(12, IPUSHQ,  3, 15, 0,     15, 0,       3, 'h44,     3, 'h45,     15, 0,       15, 0,       3, 4, 4, 15, 'h45,   'h100);
    set_vec(13, IRRMOVQ, 6, 9, 0,      15, 0,       15, 0,       15, 0,       6, 'hE1,     6, 'hE2,     6, 15, 9, 15, 'hE2,  0);

    idle();
    bus.dbg_idx = 4'h0;
    #2;
    dbg(4'h0, 64'h0, "rst_r0");
    dbg(4'hE, 64'h0, "rst_r14");
    @(negedge clk) rst = 1'b0;

    // Fill every register, confirm, then reset asynchronously mid-cycle
    for (int i = 0; i < NREG; i++) wr(4'(i), 64'h1000 + 64'(i));
    for (int i = 0; i < NREG; i++) dbg(4'(i), 64'h1000 + 64'(i), "sweep_wr");
    dbg(RNONE, 64'h0, "dbg_rnone");
    @(posedge clk);
    #3 rst = 1'b1;
    for (int i = 0; i < NREG; i++) dbg(4'(i), 64'h0, "async_rst");
    // W write presented during reset must not land
    bus.W_dstE = 4'h3; bus.W_valE = 64'hDEAD;
    @(posedge clk);
    #1 bus.W_dstE = RNONE;
    dbg(4'h3, 64'h0, "no_wr_in_rst");
    @(negedge clk) rst = 1'b0;

    wr(4'h3, 64'h11);
    dbg(4'h3, 64'h11, "wr_r3");

    // Collision: both W ports target %rsp, M data must win in the file and for a reader
    @(negedge clk);
    bus.W_dstE = RRSP; bus.W_valE = 64'hAA;
    bus.W_dstM = RRSP; bus.W_valM = 64'hBB;
    bus.D_icode = IRRMOVQ; bus.D_rA = RRSP; bus.D_rB = 4'h1;
    #1 chk("coll_fwd_valA", bus.d_valA, 64'hBB);
    @(posedge clk);
    #1 idle();
    dbg(RRSP, 64'hBB, "coll_rf");

    wr(RRSP, 64'h100);
    wr(4'h2, 64'h22);
    wr(4'h5, 64'h55);
    wr(4'h6, 64'h66);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.D_icode = vecs[i].icode; bus.D_rA = vecs[i].ra; bus.D_rB = vecs[i].rb;
      bus.D_valP = vecs[i].valp;
      bus.e_dstE = vecs[i].e_dste; bus.e_valE = vecs[i].e_vale;
      bus.M_dstE = vecs[i].m_dste; bus.M_valE = vecs[i].m_vale;
      bus.M_dstM = vecs[i].m_dstm; bus.m_valM = vecs[i].m_valm;
      bus.W_dstE = vecs[i].w_dste; bus.W_valE = vecs[i].w_vale;
      bus.W_dstM = vecs[i].w_dstm; bus.W_valM = vecs[i].w_valm;
      #1;
      chk($sformatf("v%0d_srcA", i), 64'(bus.d_srcA), 64'(vecs[i].x_srca));
      chk($sformatf("v%0d_srcB", i), 64'(bus.d_srcB), 64'(vecs[i].x_srcb));
      chk($sformatf("v%0d_dstE", i), 64'(bus.d_dstE), 64'(vecs[i].x_dste));
      chk($sformatf("v%0d_dstM", i), 64'(bus.d_dstM), 64'(vecs[i].x_dstm));
      chk($sformatf("v%0d_valA", i), bus.d_valA, vecs[i].x_vala);
      chk($sformatf("v%0d_valB", i), bus.d_valB, vecs[i].x_valb);
      // keep the table from writing the file
      #1 idle();
    end

    dbg(4'h4, 64'h100, "rf_r4_kept");
    dbg(4'h6, 64'h66, "rf_r6_kept");
    dbg(4'h2, 64'h22, "rf_r2_kept");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode/write-back stage of the Y86-64 five-stage pipeline. Sits between the D pipeline register and the E pipeline register, and drives the `d_*` inputs of the E register.
- Owns the 15-entry architectural register file. Write-back from the W stage goes into it on the clock edge.
- Generates source and destination register IDs per instruction class and resolves data hazards by forwarding from E, M and W.
- Exports `d_srcA`/`d_srcB` to pipeline control for load/use detection.

Parameters:
- NREG, 15, number of architectural registers; index 4'hF (`RNONE`) is never stored.
- WORD_W, 64, data width; must equal the `D_WORD` width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- D_icode_i  in  4  icode from the D register.
- D_rA_i  in  4  rA field.
- D_rB_i  in  4  rB field.
- D_valP_i  in  64  incremented PC.
- e_dstE_i  in  4  execute-stage dstE (already cnd-gated for cmov).
- e_valE_i  in  64  ALU result.
- M_dstE_i  in  4  M-register dstE.
- M_valE_i  in  64  M-register valE.
- M_dstM_i  in  4  M-register dstM.
- m_valM_i  in  64  memory read data.
- W_dstE_i  in  4  W-register dstE; also the register-file write port E address.
- W_valE_i  in  64  W valE; write port E data.
- W_dstM_i  in  4  W dstM; write port M address.
- W_valM_i  in  64  W valM; write port M data.
- dbg_idx_i  in  4  debug read index.
- d_srcA_o  out  4  source A ID.
- d_srcB_o  out  4  source B ID.
- d_dstE_o  out  4  destination E ID.
- d_dstM_o  out  4  destination M ID.
- d_valA_o  out  64  selected and forwarded operand A.
- d_valB_o  out  64  forwarded operand B.
- dbg_val_o  out  64  register-file contents at dbg_idx_i; 0 if dbg_idx_i = 4'hF.

Behaviour:
- Reset:
  - rst_i high clears all 15 registers to 0 immediately.
  - No writes take effect while rst_i is high.
  - All outputs are combinational, so after reset they reflect inputs with register contents = 0.
- Source A:
  - D_rA for `IRRMOVQ`, `IRMMOVQ`, `IOPQ`, `IPUSHQ`.
  - `RRSP` (4) for `IPOPQ`, `IRET`.
  - Otherwise `RNONE`.
- Source B:
  - D_rB for `IOPQ`, `IRMMOVQ`, `IMRMOVQ`.
  - `RRSP` for `IPUSHQ`, `IPOPQ`, `ICALL`, `IRET`.
  - Otherwise `RNONE`.
- Destination E:
  - D_rB for `IRRMOVQ`, `IIRMOVQ`, `IOPQ`.
  - `RRSP` for `IPUSHQ`, `IPOPQ`, `ICALL`, `IRET`.
  - Otherwise `RNONE`.
- Destination M:
  - D_rA for `IMRMOVQ`, `IPOPQ`.
  - Otherwise `RNONE`.
- Unknown icode: all four IDs are `RNONE`, and valA/valB = 0.
- valA priority (first match wins):
  1. icode `ICALL` or `IJXX` → D_valP.
  2. srcA == e_dstE → e_valE.
  3. srcA == M_dstM → m_valM.
  4. srcA == M_dstE → M_valE.
  5. srcA == W_dstM → W_valM.
  6. srcA == W_dstE → W_valE.
  7. Otherwise regfile[srcA].
- valB: same chain without step 1.
- A source of `RNONE` never matches any forwarding source. The operand is 0.
- Register-file read is combinational with no internal bypass. The same-cycle W write is covered by forwarding steps 5/6.
- Write: on posedge clk_i, regfile[W_dstE] ← W_valE if W_dstE ≠ `RNONE`; regfile[W_dstM] ← W_valM if W_dstM ≠ `RNONE`.
- Write collision: if W_dstE == W_dstM (≠ `RNONE`), the M port wins, i.e. popq %rsp leaves valM in %rsp. The forwarding order gives the same result for a reader.
- Stalls and bubbles are handled by the surrounding pipeline registers. This stage holds no pipeline state beyond the register file.

Decomposition:
- Shared `define.v` holds: icode constants (`IHALT`…`IPOPQ`), `RNONE`, `RRSP`, `NIBBLE`, `D_WORD`. No local literals for these.
- Sub-module `register_file`:
  - Ports: clk_i, rst_i; two combinational read ports; debug read port; two write ports with M-priority on collision.
  - 15×64 storage.
- `decode_stage` holds only the ID decode and the forward-select logic.

Test Plan:
- Reset, then write sweep:
  - Assert rst_i mid-run → dbg_val_o = 0 for all indices, immediately and asynchronously.
  - Write W_dstE=3, W_valE=0x11 → next cycle dbg_idx 3 reads 0x11.
- Collision:
  - W_dstE=W_dstM=4, W_valE=0xAA, W_valM=0xBB → %rsp = 0xBB.
  - A reader in the same cycle with srcA=4 gets d_valA_o = 0xBB.
- Forward priority:
  - `IOPQ` rA=2 rB=5 with e_dstE=2 (e_valE=1), M_dstM=2 (m_valM=2), W_dstE=2 (3) → d_valA_o = 1.
  - Remove the e match → 2. Remove the M match → 3.
- valP select:
  - `ICALL` with D_valP=0x40 and e_dstE=4 → d_valA_o = 0x40.
  - Same instruction: d_srcB_o = 4, d_valB_o = e_valE, d_dstE_o = 4.
- RNONE guard:
  - `IIRMOVQ` rA=F rB=7 with e_dstE=F → d_srcA_o = F, d_valA_o = 0, d_dstE_o = 7, d_dstM_o = F.
- popq decode:
  - `IPOPQ` rA=6 → srcA=4, srcB=4, dstE=4, dstM=6.
  - Register file value at 4 = 0x100 with no hazards → d_valA_o = d_valB_o = 0x100.
